// File: rtl/glitch_pkg.sv
// Shared types and widths for the glitch monitor.
package glitch_pkg;

    localparam int DELAY_W = 64;
    localparam int WIDTH_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HIGH,
        S_REPORT,
        S_REARM
    } state_t;

endpackage

// File: rtl/glitch_monitor_if.sv
// Result handshake bundle between the glitch monitor and its consumer.
interface glitch_monitor_if;
    import glitch_pkg::*;

    logic               result_valid;
    logic               result_ready;
    logic [DELAY_W-1:0] delay_count;
    logic [WIDTH_W-1:0] width_count;
    logic               timeout;
    logic               saturated;

    modport master (
        output result_valid,
        output delay_count,
        output width_count,
        output timeout,
        output saturated,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  delay_count,
        input  width_count,
        input  timeout,
        input  saturated,
        output result_ready
    );

endinterface

// File: rtl/glitch_monitor_sync_edge.sv
// Multi-flop synchronizer followed by rise/fall pulse detection.
// Edges are only reported once the synchronizer holds a real post-reset
// sample, so a line that is already high when reset releases never
// produces a rise.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   w_valid;
    logic                   w_level;

    assign w_valid = r_fill[SYNC_STAGES-1];
    assign w_level = r_sync[SYNC_STAGES-1];

    // Shift the input and a fill marker through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_fill <= '0;
            // Previous sample starts high: a rise needs a genuine low first.
            r_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds the shift chain.
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_valid ? w_level : 1'b1;
        end
    end

    assign q    = w_valid & w_level;
    assign rise = w_valid & w_level & ~r_prev;
    assign fall = w_valid & ~w_level & r_prev;

endmodule

// File: rtl/glitch_monitor.sv
// Measures trigger-to-glitch delay and glitch width in clk cycles and
// presents the result through a valid/ready handshake.
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter logic [DELAY_W-1:0] TIMEOUT_CYCLES = 64'd204_000_000,
    parameter int                 SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             glitch,
    output logic             busy,
    glitch_monitor_if.master res
);
    localparam logic [DELAY_W-1:0] DELAY_MAX = '1;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

    logic w_trig_level, w_trig_rise, w_trig_fall;
    logic w_glitch_level, w_glitch_rise, w_glitch_fall;
    logic w_unused;

    state_t             r_state, w_state_nxt;
    logic [DELAY_W-1:0] r_delay, w_delay_nxt, w_delay_inc;
    logic [WIDTH_W-1:0] r_width, w_width_nxt, w_width_inc;
    logic               r_sat, w_sat_nxt, r_tmo, w_tmo_nxt;
    logic               w_delay_hit, w_width_hit, w_load;

    logic [DELAY_W-1:0] r_res_delay;
    logic [WIDTH_W-1:0] r_res_width;
    logic               r_res_tmo, r_res_sat;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trigger (
        .clk  (clk),
        .rst  (rst),
        .d    (trigger),
        .q    (w_trig_level),
        .rise (w_trig_rise),
        .fall (w_trig_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_glitch (
        .clk  (clk),
        .rst  (rst),
        .d    (glitch),
        .q    (w_glitch_level),
        .rise (w_glitch_rise),
        .fall (w_glitch_fall)
    );

    // Trigger falls and the glitch level are not needed by the FSM.
    assign w_unused = w_trig_fall | w_glitch_level;

    // Saturating increments: stick at all-ones and flag when reached.
    assign w_delay_inc = (r_delay == DELAY_MAX) ? DELAY_MAX : r_delay + DELAY_W'(1);
    assign w_width_inc = (r_width == WIDTH_MAX) ? WIDTH_MAX : r_width + WIDTH_W'(1);
    assign w_delay_hit = (w_delay_inc == DELAY_MAX);
    assign w_width_hit = (w_width_inc == WIDTH_MAX);

    // Next-state and counter update logic.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_width_nxt = r_width;
        w_sat_nxt   = r_sat;
        w_tmo_nxt   = r_tmo;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_trig_rise) begin
                    w_delay_nxt = '0;
                    w_width_nxt = '0;
                    w_sat_nxt   = 1'b0;
                    w_tmo_nxt   = 1'b0;
                    if (w_glitch_rise) begin
                        w_width_nxt = WIDTH_W'(1);
                        w_state_nxt = S_HIGH;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                w_delay_nxt = w_delay_inc;
                w_sat_nxt   = r_sat | w_delay_hit;
                if (w_glitch_rise) begin
                    w_width_nxt = WIDTH_W'(1);
                    w_state_nxt = S_HIGH;
                end else if (w_delay_inc >= TIMEOUT_CYCLES) begin
                    w_tmo_nxt   = 1'b1;
                    w_width_nxt = '0;
                    w_load      = 1'b1;
                    w_state_nxt = S_REPORT;
                end
            end
            S_HIGH: begin
                if (w_glitch_fall) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_REPORT;
                end else begin
                    w_width_nxt = w_width_inc;
                    w_sat_nxt   = r_sat | w_width_hit;
                end
            end
            S_REPORT: begin
                if (res.result_ready) begin
                    w_state_nxt = w_trig_level ? S_REARM : S_IDLE;
                end
            end
            S_REARM: begin
                if (!w_trig_level) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and working counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_delay <= '0;
            r_width <= '0;
            r_sat   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_delay <= w_delay_nxt;
            r_width <= w_width_nxt;
            r_sat   <= w_sat_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // Result registers: captured on REPORT entry, held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_delay <= '0;
            r_res_width <= '0;
            r_res_tmo   <= 1'b0;
            r_res_sat   <= 1'b0;
        end else if (w_load) begin
            r_res_delay <= w_delay_nxt;
            r_res_width <= w_width_nxt;
            r_res_tmo   <= w_tmo_nxt;
            r_res_sat   <= w_sat_nxt;
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign res.result_valid = (r_state == S_REPORT);
    assign res.delay_count  = r_res_delay;
    assign res.width_count  = r_res_width;
    assign res.timeout      = r_res_tmo;
    assign res.saturated    = r_res_sat;

endmodule

// File: tb/tb_glitch_monitor.sv
// Directed bench for glitch_monitor: table of delay/width vectors plus
// hand sequences for back-pressure, timeout, saturation and reset.
module tb_glitch_monitor;
    import glitch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic trigger, glitch, busy;
    logic trigger_t, busy_t;
    logic glitch_t;

    glitch_monitor_if res_if ();
    glitch_monitor_if to_if ();

    always #5 clk = ~clk;

    glitch_monitor #(.TIMEOUT_CYCLES(64'd1000), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .glitch  (glitch),
        .busy    (busy),
        .res     (res_if)
    );

    glitch_monitor #(.TIMEOUT_CYCLES(64'd50), .SYNC_STAGES(2)) dut_to (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger_t),
        .glitch  (glitch_t),
        .busy    (busy_t),
        .res     (to_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int unsigned dly;
        int unsigned wid;
        logic [63:0] exp_delay;
        logic [63:0] exp_width;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Wait (bounded) at negedges for result_valid on the chosen instance.
    task automatic wait_valid(input bit use_to, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            cycles++;
            if ((use_to ? to_if.result_valid : res_if.result_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 50; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        check(name, busy, 1'b0);
    endtask

    // Trigger rise now, glitch rise d cycles later, glitch high w cycles.
    task automatic pulse_meas(input int unsigned d, input int unsigned w);
        trigger = 1'b1;
        if (d != 0) repeat (d) @(negedge clk);
        glitch = 1'b1;
        repeat (w) @(negedge clk);
        glitch = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  ok;
        bit  stable;
        int  n_valid;

        vecs[0] = '{100, 5,  64'd100, 64'd5};
        vecs[1] = '{0,   3,  64'd0,   64'd3};
        vecs[2] = '{1,   1,  64'd1,   64'd1};
        vecs[3] = '{7,   12, 64'd7,   64'd12};
        vecs[4] = '{33,  2,  64'd33,  64'd2};

        rst = 1'b1; trigger = 1'b1; glitch = 1'b0;
        trigger_t = 1'b0; glitch_t = 1'b0;
        res_if.result_ready = 1'b1;
        to_if.result_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", res_if.result_valid, 1'b0);
        check("reset_delay", res_if.delay_count, 64'd0);
        check("reset_width", res_if.width_count, 64'd0);
        check("reset_flags", {res_if.timeout, res_if.saturated}, 64'd0);

        // Trigger already high when reset releases must not start anything.
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_start_high_trigger", busy, 1'b0);
        trigger = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            pulse_meas(vecs[i].dly, vecs[i].wid);
            wait_valid(1'b0, cyc, ok);
            check($sformatf("vec%0d_valid_seen", i), ok, 1'b1);
            check($sformatf("vec%0d_delay", i), res_if.delay_count, vecs[i].exp_delay);
            check($sformatf("vec%0d_width", i), res_if.width_count, vecs[i].exp_width);
            check($sformatf("vec%0d_flags", i), {res_if.timeout, res_if.saturated}, 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_single_valid", i), res_if.result_valid, 1'b0);
            check($sformatf("vec%0d_hold_delay", i), res_if.delay_count, vecs[i].exp_delay);
            check($sformatf("vec%0d_rearm_busy", i), busy, 1'b1);
            trigger = 1'b0;
            wait_idle($sformatf("vec%0d_idle", i));
        end

        // Glitch already high at trigger rise is not an edge.
        glitch = 1'b1;
        repeat (5) @(negedge clk);
        trigger = 1'b1;
        repeat (5) @(negedge clk);
        glitch = 1'b0;
        repeat (15) @(negedge clk);
        glitch = 1'b1;
        repeat (2) @(negedge clk);
        glitch = 1'b0;
        wait_valid(1'b0, cyc, ok);
        check("pre_high_valid_seen", ok, 1'b1);
        check("pre_high_delay", res_if.delay_count, 64'd20);
        check("pre_high_width", res_if.width_count, 64'd2);
        trigger = 1'b0;
        wait_idle("pre_high_idle");

        // Back-pressure: result held and glitch activity ignored.
        res_if.result_ready = 1'b0;
        pulse_meas(10, 4);
        wait_valid(1'b0, cyc, ok);
        check("bp_valid_seen", ok, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            glitch = ~glitch;
            @(negedge clk);
            if (!(res_if.result_valid === 1'b1 && res_if.delay_count === 64'd10 &&
                  res_if.width_count === 32'd4 && res_if.timeout === 1'b0))
                stable = 1'b0;
        end
        glitch = 1'b0;
        check("bp_stable", stable, 1'b1);
        res_if.result_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_drop", res_if.result_valid, 1'b0);
        check("bp_rearm_busy", busy, 1'b1);
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            glitch = ~glitch;
            @(negedge clk);
            if (res_if.result_valid === 1'b1) n_valid++;
        end
        glitch = 1'b0;
        check("bp_no_second_result", n_valid, 0);
        trigger = 1'b0;
        wait_idle("bp_idle");

        // Timeout on the short-timeout instance.
        trigger_t = 1'b1;
        wait_valid(1'b1, cyc, ok);
        check("to_valid_seen", ok, 1'b1);
        check("to_latency", cyc, 53);
        check("to_delay", to_if.delay_count, 64'd50);
        check("to_width", to_if.width_count, 64'd0);
        check("to_timeout", to_if.timeout, 1'b1);
        check("to_saturated", to_if.saturated, 1'b0);
        trigger_t = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy_t === 1'b0) break;
            @(negedge clk);
        end
        check("to_idle", busy_t, 1'b0);

        // Width saturation with the counter preloaded near its limit.
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b1;
        repeat (6) @(negedge clk);
        force dut.r_width = 32'hFFFF_FFF0;
        @(negedge clk);
        release dut.r_width;
        repeat (30) @(negedge clk);
        glitch = 1'b0;
        wait_valid(1'b0, cyc, ok);
        check("sat_valid_seen", ok, 1'b1);
        check("sat_delay", res_if.delay_count, 64'd3);
        check("sat_width", res_if.width_count, 64'hFFFF_FFFF);
        check("sat_flag", res_if.saturated, 1'b1);
        check("sat_timeout", res_if.timeout, 1'b0);
        trigger = 1'b0;
        wait_idle("sat_idle");

        // Reset during HIGH clears everything immediately.
        trigger = 1'b1;
        repeat (4) @(negedge clk);
        glitch = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", res_if.result_valid, 1'b0);
        check("rst_delay", res_if.delay_count, 64'd0);
        check("rst_width", res_if.width_count, 64'd0);
        check("rst_flags", {res_if.timeout, res_if.saturated}, 64'd0);
        @(negedge clk);
        trigger = 1'b0;
        glitch  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_if.result_valid === 1'b1 || busy === 1'b1) n_valid++;
        end
        check("rst_discard", n_valid, 0);
        pulse_meas(12, 6);
        wait_valid(1'b0, cyc, ok);
        check("post_rst_valid_seen", ok, 1'b1);
        check("post_rst_delay", res_if.delay_count, 64'd12);
        check("post_rst_width", res_if.width_count, 64'd6);
        check("post_rst_flags", {res_if.timeout, res_if.saturated}, 64'd0);
        trigger = 1'b0;
        wait_idle("post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/glitch_monitor.md
GLITCH_MONITOR -- requirements
Module: glitch_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64'd204_000_000, meaning max delay cycles waited after trigger before abandoning (1 s at 204 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on each asynchronous input (min 2).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 trigger  input  1  asynchronous trigger line shared with the glitch generator.
REQ-007 glitch  input  1  asynchronous glitch line under measurement.
REQ-008 result_ready  input  1  consumer accepts the result.
REQ-009 result_valid  output  1  measurement result available.
REQ-010 delay_count  output  64  clk cycles from trigger rise to glitch rise.
REQ-011 width_count  output  32  clk cycles glitch held high.
REQ-012 timeout  output  1  result is a timeout (no glitch seen).
REQ-013 saturated  output  1  a counter hit its all-ones limit.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 trigger and glitch SHALL each pass through SYNC_STAGES flops, then rising/falling-edge detect; equal latency on both keeps delay unbiased.
REQ-016 States SHALL be IDLE, ARMED, HIGH, REPORT, REARM.
REQ-017 IDLE: on synced trigger rise -> ARMED with delay counter cleared; if glitch rise detected same cycle -> HIGH with delay_count 0.
REQ-018 delay_count SHALL equal N when glitch rise is detected N cycles after trigger rise detection.
REQ-019 ARMED: delay counter +1 per cycle; glitch rise -> HIGH; glitch already high at trigger rise SHALL NOT count (edge only).
REQ-020 ARMED: when counter reaches TIMEOUT_CYCLES without glitch rise -> REPORT, timeout=1, width_count=0.
REQ-021 trigger fall during ARMED or HIGH SHALL be ignored.
REQ-022 HIGH: width_count SHALL equal number of cycles synced glitch is high (rise cycle counts as 1); glitch fall -> REPORT.
REQ-023 Both counters SHALL saturate at all-ones, never wrap, and set saturated.
REQ-024 REPORT: result_valid=1; delay_count, width_count, timeout, saturated SHALL stay stable until result_valid && result_ready.
REQ-025 On handshake: synced trigger low -> IDLE, else -> REARM; result_valid drops next cycle.
REQ-026 REARM: wait for synced trigger low -> IDLE; trigger/glitch edges in REPORT or REARM SHALL be ignored.
REQ-027 result_ready high outside REPORT SHALL have no effect.
REQ-028 Result outputs SHALL hold last reported values after handshake until next REPORT entry.

Reset
REQ-029 rst SHALL force IDLE, clear synchronizers, counters, result_valid, delay_count, width_count, timeout, saturated, busy to 0 immediately.
REQ-030 rst mid-measurement SHALL discard the measurement; no result produced.
REQ-031 After rst release, trigger already high SHALL NOT start a measurement (synchronizers reset low; start requires a rise seen after release... only if trigger was low for at least one synced sample).

Structure
REQ-032 Package glitch_pkg SHALL hold the state enum, DELAY_W=64, WIDTH_W=32.
REQ-033 Sub-module sync_edge (synchronizer + rise/fall pulse) SHALL be instantiated once per input.

Verification
REQ-034 trigger rise, glitch rise 100 cycles later, high 5 cycles, ready=1 -> one result_valid, delay_count=100, width_count=5, timeout=0.
REQ-035 TIMEOUT_CYCLES=50, trigger rise, no glitch -> result at 50 cycles, timeout=1, width_count=0.
REQ-036 ready=0 for 20 cycles in REPORT, glitch pulses meanwhile -> outputs stable, no second result; ready=1 -> handshake, REARM until trigger low.
REQ-037 trigger and glitch rise same cycle, glitch high 3 cycles -> delay_count=0, width_count=3.
REQ-038 rst asserted during HIGH -> all outputs 0 same cycle; after release, fresh trigger gives correct new result.
REQ-039 glitch held high beyond 2^32-1 cycles (forced counter) -> width_count=32'hFFFF_FFFF, saturated=1.
